imem_loader: RTL and testbench

Write-side companion to the instruction memory. Accepts a byte stream over a valid/ready handshake, packs bytes big-endian into 32-bit MIPS instruction words, and drives a synchronous write port into the instruction memory array at consecutive word addresses. Holds the CPU core (`cpu_hold`) until the programmed number of words has been written. Sits between the host/boot byte source and the instruction memory write port.

---
 rtl/imem_loader.sv | 155 +++++++++++++++
 tb/tb_imem_loader.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream to 32-bit instruction-word loader for the instruction memory write port.
// Optional trailing XOR checksum byte is enabled with `define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int NMEM = 15,
    parameter int AW   = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          busy,
    output logic          done,
    output logic          cpu_hold,
    output logic          err,
    output logic [2:0]    dbg_state
);

    // Handshake: a byte moves on a rising edge where in_valid && in_ready; in_ready
    // depends on state only, and the source must hold in_data until it is taken.
`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        WRITE   = 3'd2,
        DONE    = 3'd3,
        CHECK   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        WRITE   = 3'd2,
        DONE    = 3'd3
    } state_t;
`endif

    state_t        state, state_n;
    logic [AW-1:0] idx;
    logic [1:0]    cnt;
    logic [31:0]   sr;
    logic          accept;
    logic          last_word;
    logic          restart;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]    acc;
    logic          err_q;
`endif

    assign accept    = in_valid && in_ready;
    assign last_word = (idx == AW'(NMEM - 1));
    assign restart   = start && (state == IDLE || state == DONE);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = COLLECT;
            COLLECT: if (accept && cnt == 2'd3) state_n = WRITE;
`ifdef IMEM_LOADER_CHECKSUM_EN
            WRITE:   state_n = last_word ? CHECK : COLLECT;
            CHECK:   if (accept) state_n = DONE;
`else
            WRITE:   state_n = last_word ? DONE : COLLECT;
`endif
            DONE:    if (start) state_n = COLLECT;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        mem_we   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            COLLECT: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            WRITE: begin
                mem_we = 1'b1;
                busy   = 1'b1;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
`endif
            DONE:    done = 1'b1;
            default: ;
        endcase
        cpu_hold = !done;
    end

    // Address and data are captured with the 4th byte so they are stable for the
    // whole WRITE cycle and keep their last values afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            cnt       <= '0;
            sr        <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (restart) begin
            idx <= '0;
            cnt <= '0;
            sr  <= '0;
        end else if (state == COLLECT && accept) begin
            sr  <= {sr[23:0], in_data};
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
                mem_addr  <= idx;
                mem_wdata <= {sr[23:0], in_data};
            end
        end else if (state == WRITE && !last_word) begin
            idx <= idx + AW'(1);
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            err_q <= 1'b0;
        end else if (restart) begin
            acc   <= '0;
            err_q <= 1'b0;
        end else if (state == COLLECT && accept) begin
            acc <= acc ^ in_data;
        end else if (state == CHECK && accept && in_data != acc) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: NMEM=2 and NMEM=15 instances (plus NMEM=1 when the
// checksum macro is defined) share the byte source; a negedge monitor scores every write.
`timescale 1ns/1ps
module tb_imem_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic start_v = 1'b0;
  int sel = 0;

  logic start0, ready0, we0, busy0, done0, hold0, err0;
  logic [6:0] addr0;
  logic [31:0] wdata0;
  logic [2:0] st0;
  logic start1, ready1, we1, busy1, done1, hold1, err1;
  logic [6:0] addr1;
  logic [31:0] wdata1;
  logic [2:0] st1;

  logic s_ready, s_we, s_busy, s_done, s_hold, s_err;
  logic [6:0] s_addr;
  logic [31:0] s_wdata;
  int s_nmem;

  int checks = 0;
  int errors = 0;
  logic [38:0] exp_q[$];
  logic [7:0] src[$];
  logic [7:0] xacc;
  logic prev_we = 1'b0;

  always #5 clk = ~clk;

  assign start0 = start_v && (sel == 0);
  assign start1 = start_v && (sel == 1);

  imem_loader #(.NMEM(2), .AW(7)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ready0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wdata0),
    .busy(busy0), .done(done0), .cpu_hold(hold0), .err(err0), .dbg_state(st0)
  );

  imem_loader #(.NMEM(15), .AW(7)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ready1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1),
    .busy(busy1), .done(done1), .cpu_hold(hold1), .err(err1), .dbg_state(st1)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic start2, ready2, we2, busy2, done2, hold2, err2;
  logic [6:0] addr2;
  logic [31:0] wdata2;
  logic [2:0] st2;
  assign start2 = start_v && (sel == 2);

  imem_loader #(.NMEM(1), .AW(7)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ready2), .mem_we(we2), .mem_addr(addr2), .mem_wdata(wdata2),
    .busy(busy2), .done(done2), .cpu_hold(hold2), .err(err2), .dbg_state(st2)
  );
`endif

  always_comb begin
    s_ready = ready0; s_we = we0; s_busy = busy0; s_done = done0;
    s_hold = hold0; s_err = err0; s_addr = addr0; s_wdata = wdata0; s_nmem = 2;
    if (sel == 1) begin
      s_ready = ready1; s_we = we1; s_busy = busy1; s_done = done1;
      s_hold = hold1; s_err = err1; s_addr = addr1; s_wdata = wdata1; s_nmem = 15;
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (sel == 2) begin
      s_ready = ready2; s_we = we2; s_busy = busy2; s_done = done2;
      s_hold = hold2; s_err = err2; s_addr = addr2; s_wdata = wdata2; s_nmem = 1;
    end
`endif
  end

  // Scoreboard: every write of the selected instance must match the next expected {addr,data}.
  always @(negedge clk) begin
    logic [38:0] e;
    if (rst_n && s_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected: got addr=%0d data=%h, none expected", s_addr, s_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({s_addr, s_wdata} !== e) begin
          errors++;
          $display("FAIL write_word: got addr=%0d data=%h, expected addr=%0d data=%h",
                   s_addr, s_wdata, e[38:32], e[31:0]);
        end
      end
      checks++;
      if (prev_we !== 1'b0) begin
        errors++;
        $display("FAIL we_width: mem_we high two cycles in a row at addr=%0d", s_addr);
      end
      checks++;
      if (int'(s_addr) >= s_nmem) begin
        errors++;
        $display("FAIL addr_range: got addr=%0d, limit %0d", s_addr, s_nmem - 1);
      end
    end
    prev_we = s_we;
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    in_valid = 1'b1;
    in_data = b;
    t = 0;
    while (s_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 50) begin
      errors++;
      $display("FAIL byte_timeout: in_ready=%b after %0d cycles, expected 1", s_ready, t);
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulse_start();
    start_v = 1'b1;
    @(negedge clk);
    start_v = 1'b0;
    checks++;
    if (s_ready !== 1'b1 || s_busy !== 1'b1) begin
      errors++;
      $display("FAIL start_latency: in_ready=%b busy=%b, expected 1 1", s_ready, s_busy);
    end
  endtask

  // Sends src[0..nbytes-1]; a complete word is expected at address i/4.
  task automatic load(input int nbytes, input int gap, input int start_at);
    logic [31:0] w;
    w = 32'h0;
    xacc = 8'h00;
    for (int i = 0; i < nbytes; i++) begin
      if (i == start_at) begin
        start_v = 1'b1;
        @(negedge clk);
        start_v = 1'b0;
      end
      w = {w[23:0], src[i]};
      xacc = xacc ^ src[i];
      if (i % 4 == 3) exp_q.push_back({7'(i / 4), w});
      send_byte(src[i], gap);
    end
  endtask

  task automatic finish_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(xacc, 0);
`endif
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (s_done !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (s_done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout: done=%b after %0d cycles, expected 1", s_done, t);
    end
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_writes: %0d words not written, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if ({s_ready, s_we, s_busy, s_done, s_hold, s_err} !== 6'b000010 ||
        s_addr !== 7'd0 || s_wdata !== 32'h0) begin
      errors++;
      $display("FAIL %s: ready=%b we=%b busy=%b done=%b hold=%b err=%b addr=%0d data=%h, expected 0 0 0 0 1 0 0 0",
               tag, s_ready, s_we, s_busy, s_done, s_hold, s_err, s_addr, s_wdata);
    end
  endtask

  task automatic set_src_basic();
    src.delete();
    src = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h3C, 8'h01, 8'h00, 8'h10};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sel = 0;
    repeat (2) @(negedge clk);
    check_reset_values("reset_values");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("idle_after_reset");
  endtask

  task automatic test_basic();
    sel = 0;
    set_src_basic();
    pulse_start();
    load(8, 0, -1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    finish_load();
`else
    checks++;
    if (s_we !== 1'b1 || s_done !== 1'b0) begin
      errors++;
      $display("FAIL last_write: we=%b done=%b, expected 1 0", s_we, s_done);
    end
    @(negedge clk);
    checks++;
    if (s_done !== 1'b1 || s_hold !== 1'b0 || s_busy !== 1'b0) begin
      errors++;
      $display("FAIL done_timing: done=%b hold=%b busy=%b, expected 1 0 0", s_done, s_hold, s_busy);
    end
`endif
    wait_done();
    checks++;
    if (s_addr !== 7'd1 || s_wdata !== 32'h3C010010 || s_err !== 1'b0 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL hold_outputs: addr=%0d data=%h err=%b ready=%b, expected 1 3c010010 0 0",
               s_addr, s_wdata, s_err, s_ready);
    end
  endtask

  task automatic test_throttle();
    sel = 0;
    set_src_basic();
    pulse_start();
    load(8, 1, -1);
    finish_load();
    wait_done();
  endtask

  task automatic test_start_ignored();
    sel = 0;
    set_src_basic();
    pulse_start();
    load(8, 0, 2);
    finish_load();
    wait_done();
  endtask

  task automatic test_reset_midload();
    sel = 0;
    src.delete();
    src = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
    pulse_start();
    load(6, 0, -1);
    rst_n = 1'b0;
    #1;
    check_reset_values("async_reset_midload");
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL word0_before_reset: %0d words pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("idle_after_abort");
    src.delete();
    src = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    pulse_start();
    load(8, 0, -1);
    finish_load();
    wait_done();
  endtask

  task automatic test_nmem15();
    sel = 1;
    src.delete();
    for (int i = 0; i < 60; i++) src.push_back(8'(i));
    pulse_start();
    load(60, 0, -1);
    finish_load();
    wait_done();
    checks++;
    if (s_addr !== 7'd14 || s_wdata !== 32'h38393A3B || s_hold !== 1'b0) begin
      errors++;
      $display("FAIL nmem15_last: addr=%0d data=%h hold=%b, expected 14 38393a3b 0", s_addr, s_wdata, s_hold);
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    sel = 2;
    src.delete();
    src = '{8'h01, 8'h02, 8'h04, 8'h08};
    pulse_start();
    load(4, 0, -1);
    send_byte(8'h0F, 0);
    wait_done();
    checks++;
    if (s_err !== 1'b0 || s_done !== 1'b1) begin
      errors++;
      $display("FAIL checksum_good: err=%b done=%b, expected 0 1", s_err, s_done);
    end
    pulse_start();
    load(4, 0, -1);
    send_byte(8'h0E, 0);
    wait_done();
    checks++;
    if (s_err !== 1'b1 || s_done !== 1'b1) begin
      errors++;
      $display("FAIL checksum_bad: err=%b done=%b, expected 1 1", s_err, s_done);
    end
    pulse_start();
    checks++;
    if (s_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: err=%b after start, expected 0", s_err);
    end
    load(4, 0, -1);
    send_byte(8'h0F, 0);
    wait_done();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_throttle();
    test_start_ignored();
    test_reset_midload();
    test_nmem15();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
